// File: rtl/core_sequencer_if.sv
// rtl/core_sequencer_if.sv - instruction/data memory handshake bundle for core_sequencer
interface core_sequencer_if;
    logic imem_req_o;
    logic imem_valid_i;
    logic dmem_req_o;
    logic dmem_we_o;
    logic dmem_valid_i;

    modport master (
        output imem_req_o,
        input  imem_valid_i,
        output dmem_req_o,
        output dmem_we_o,
        input  dmem_valid_i
    );

    modport slave (
        input  imem_req_o,
        output imem_valid_i,
        input  dmem_req_o,
        input  dmem_we_o,
        output dmem_valid_i
    );
endinterface

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/exec/mem/writeback control sequencer
module core_sequencer #(
    parameter int DWIDTH      = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [6:0]        opcode_i,
    input  logic              br_taken_i,
    core_sequencer_if.master  mem_if,
    output logic              insn_we_o,
    output logic              pc_we_o,
    output logic [1:0]        pc_sel_o,
    output logic              rf_we_o,
    output logic [1:0]        wb_sel_o,
    output logic [2:0]        state_o,
    output logic              trap_o,
    output logic [DWIDTH-1:0] retire_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILLEGAL
    } class_e;

    localparam int            WCW       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    class_e            cls_q, cls_d, dec_class;
    logic              br_q, br_d;
    logic [WCW-1:0]    wait_q, wait_d;
    logic [DWIDTH-1:0] retire_q, retire_d;

    logic imem_req, dmem_req, dmem_we, insn_we, pc_we, rf_we;
    logic [1:0] pc_sel, wb_sel;

    always_comb begin
        dec_class = C_ILLEGAL;
        case (opcode_i)
            7'b0110011: dec_class = C_R;
            7'b0010011: dec_class = C_I;
            7'b0000011: dec_class = C_LOAD;
            7'b0100011: dec_class = C_STORE;
            7'b1100011: dec_class = C_BRANCH;
            7'b1101111: dec_class = C_JAL;
            7'b1100111: dec_class = C_JALR;
            7'b0110111: dec_class = C_LUI;
            7'b0010111: dec_class = C_AUIPC;
            default:    dec_class = C_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cls_q    <= C_R;
            br_q     <= 1'b0;
            wait_q   <= '0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            br_q     <= br_d;
            wait_q   <= wait_d;
            retire_q <= retire_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        br_d     = br_q;
        wait_d   = wait_q;
        retire_d = retire_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        insn_we  = 1'b0;
        pc_we    = 1'b0;
        rf_we    = 1'b0;
        pc_sel   = 2'b00;
        wb_sel   = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (mem_if.imem_valid_i) begin
                    insn_we = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    // the last allowed wait cycle has passed with no response
                    wait_d = wait_q + WCW'(1);
                    if (wait_q == WAIT_LAST) state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                cls_d   = dec_class;
                state_d = (dec_class == C_ILLEGAL) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                br_d = br_taken_i;
                if (cls_q == C_LOAD || cls_q == C_STORE) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == C_STORE);
                if (mem_if.dmem_valid_i) begin
                    state_d = S_WB;
                end else begin
                    wait_d = wait_q + WCW'(1);
                    if (wait_q == WAIT_LAST) state_d = S_TRAP;
                end
            end
            S_WB: begin
                pc_we    = 1'b1;
                rf_we    = !(cls_q == C_STORE || cls_q == C_BRANCH);
                if (cls_q == C_LOAD)                          wb_sel = 2'b01;
                else if (cls_q == C_JAL || cls_q == C_JALR)   wb_sel = 2'b10;
                if (cls_q == C_JAL || (cls_q == C_BRANCH && br_q)) pc_sel = 2'b01;
                else if (cls_q == C_JALR)                          pc_sel = 2'b10;
                retire_d = retire_q + DWIDTH'(1);
                state_d  = S_FETCH;
                wait_d   = '0;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    assign mem_if.imem_req_o = imem_req;
    assign mem_if.dmem_req_o = dmem_req;
    assign mem_if.dmem_we_o  = dmem_we;
    assign insn_we_o         = insn_we;
    assign pc_we_o           = pc_we;
    assign rf_we_o           = rf_we;
    assign pc_sel_o          = pc_sel;
    assign wb_sel_o          = wb_sel;
    assign state_o           = state_q;
    assign trap_o            = (state_q == S_TRAP);
    assign retire_cnt_o      = retire_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - randomized self-checking bench for core_sequencer
module tb_core_sequencer;
    localparam int DWIDTH      = 4;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_MOD     = 1 << DWIDTH;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic clk = 1'b0;
    logic rst, start_i, br_taken_i;
    logic [6:0] opcode_i;
    logic insn_we_o, pc_we_o, rf_we_o, trap_o;
    logic [1:0] pc_sel_o, wb_sel_o;
    logic [2:0] state_o;
    logic [DWIDTH-1:0] retire_cnt_o;
    logic [9:0] strobes;

    core_sequencer_if mem_if();

    core_sequencer #(.DWIDTH(DWIDTH), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .opcode_i(opcode_i),
        .br_taken_i(br_taken_i), .mem_if(mem_if), .insn_we_o(insn_we_o),
        .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .rf_we_o(rf_we_o),
        .wb_sel_o(wb_sel_o), .state_o(state_o), .trap_o(trap_o),
        .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk = ~clk;

    assign strobes = {mem_if.imem_req_o, insn_we_o, mem_if.dmem_req_o, mem_if.dmem_we_o,
                      pc_we_o, rf_we_o, pc_sel_o, wb_sel_o};

    int n_checks = 0;
    int n_errors = 0;
    int exp_retire = 0;
    logic [6:0] legal_ops [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                  OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [9:0] stb(input logic ireq, input logic iwe, input logic dreq,
                                       input logic dwe, input logic pcwe, input logic rfwe,
                                       input logic [1:0] pcs, input logic [1:0] wbs);
        return {ireq, iwe, dreq, dwe, pcwe, rfwe, pcs, wbs};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        opcode_i            = 7'($urandom);
        br_taken_i          = 1'($urandom);
        mem_if.imem_valid_i = 1'($urandom);
        mem_if.dmem_valid_i = 1'($urandom);
    endtask

    task automatic expect_cycle(input string tag, input int st, input logic [9:0] exp_stb);
        #1;
        check({tag, " state"}, 32'(state_o), st);
        check({tag, " strobes"}, 32'(strobes), 32'(exp_stb));
        check({tag, " trap"}, 32'(trap_o), 32'(st == 6));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        start_i = 1'($urandom);
        noise();
        repeat (cycles) tick();
        rst = 1'b0;
        start_i = 1'b0;
        noise();
        exp_retire = 0;
        expect_cycle("reset", 0, '0);
        check("reset retire", 32'(retire_cnt_o), 0);
        tick();
    endtask

    task automatic idle_wait(input int n);
        repeat (n) begin
            noise();
            start_i = 1'b0;
            expect_cycle("idle", 0, '0);
            tick();
        end
    endtask

    task automatic do_start();
        noise();
        start_i = 1'b1;
        expect_cycle("start", 0, '0);
        tick();
        start_i = 1'b0;
    endtask

    task automatic hold_trap(input int n);
        repeat (n) begin
            noise();
            start_i = 1'($urandom);
            expect_cycle("trap hold", 6, '0);
            tick();
        end
        start_i = 1'b0;
    endtask

    // One instruction from the first FETCH cycle; fdly/mdly = wait cycles before valid.
    // status: 0 retired, 1 trapped, 2 reset during MEM.
    task automatic run_insn(input logic [6:0] op, input int fdly, input int mdly,
                            input logic br, input int rst_mem, output int status);
        bit ld, st, brn, jal, jalr;
        logic [1:0] pcs, wbs;
        ld = (op == OP_LOAD); st = (op == OP_STORE); brn = (op == OP_BRANCH);
        jal = (op == OP_JAL); jalr = (op == OP_JALR);
        status = 0;

        for (int c = 0; c < MEM_TIMEOUT; c++) begin
            noise();
            mem_if.imem_valid_i = (c == fdly);
            expect_cycle("fetch", 1, stb(1'b1, c == fdly, 0, 0, 0, 0, 2'b00, 2'b00));
            tick();
            if (c == fdly) break;
        end
        if (fdly >= MEM_TIMEOUT) begin
            noise();
            expect_cycle("fetch timeout", 6, '0);
            tick();
            status = 1;
            return;
        end

        noise();
        opcode_i = op;
        expect_cycle("decode", 2, '0);
        tick();
        if (!is_legal(op)) begin
            noise();
            expect_cycle("illegal", 6, '0);
            tick();
            status = 1;
            return;
        end

        noise();
        opcode_i = op;
        br_taken_i = br;
        expect_cycle("exec", 3, '0);
        tick();

        if (ld || st) begin
            for (int c = 0; c < MEM_TIMEOUT; c++) begin
                noise();
                opcode_i = op;
                mem_if.dmem_valid_i = (c == mdly);
                expect_cycle("mem", 4, stb(0, 0, 1'b1, st, 0, 0, 2'b00, 2'b00));
                if (c == rst_mem) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    noise();
                    exp_retire = 0;
                    expect_cycle("mem reset", 0, '0);
                    check("mem reset retire", 32'(retire_cnt_o), 0);
                    tick();
                    status = 2;
                    return;
                end
                tick();
                if (c == mdly) break;
            end
            if (mdly >= MEM_TIMEOUT) begin
                noise();
                expect_cycle("mem timeout", 6, '0);
                tick();
                status = 1;
                return;
            end
        end

        pcs = (jal || (brn && br)) ? 2'b01 : (jalr ? 2'b10 : 2'b00);
        wbs = ld ? 2'b01 : ((jal || jalr) ? 2'b10 : 2'b00);
        noise();
        opcode_i = op;
        expect_cycle("wb", 5, stb(0, 0, 0, 0, 1'b1, !(st || brn), pcs, wbs));
        check("wb retire", 32'(retire_cnt_o), 32'(exp_retire));
        tick();
        exp_retire = (exp_retire + 1) % CNT_MOD;
        check("retire", 32'(retire_cnt_o), 32'(exp_retire));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s;
        logic [6:0] op;
        rst = 1'b1; start_i = 1'b0; opcode_i = '0; br_taken_i = 1'b0;
        mem_if.imem_valid_i = 1'b0; mem_if.dmem_valid_i = 1'b0;
        #1;
        do_reset(2);
        idle_wait(4);
        do_start();

        run_insn(OP_R,      0, 0, 1'b0, -1, s);
        run_insn(OP_LOAD,   0, 3, 1'b0, -1, s);
        run_insn(OP_BRANCH, 1, 0, 1'b1, -1, s);
        run_insn(OP_BRANCH, 0, 0, 1'b0, -1, s);
        run_insn(OP_JAL,    2, 0, 1'b1, -1, s);
        run_insn(OP_JALR,   0, 0, 1'b1, -1, s);
        run_insn(OP_LUI,    3, 0, 1'b0, -1, s);
        run_insn(OP_AUIPC,  0, 0, 1'b1, -1, s);
        run_insn(OP_STORE,  1, 2, 1'b0, -1, s);
        run_insn(OP_I,     15, 0, 1'b0, -1, s);
        run_insn(OP_STORE,  0, 15, 1'b1, -1, s);

        for (int k = 0; k < 40; k++) begin
            op = legal_ops[$urandom_range(0, 8)];
            run_insn(op, $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom), -1, s);
        end

        run_insn(OP_LOAD, 0, 10, 1'b0, 2, s);
        idle_wait(3);
        do_start();

        run_insn(OP_R, 99, 0, 1'b0, -1, s);
        hold_trap(12);
        do_reset(1);
        idle_wait(2);
        do_start();

        run_insn(7'b0000000, 0, 0, 1'b0, -1, s);
        hold_trap(12);
        do_reset(1);
        do_start();

        run_insn(OP_STORE, 0, 99, 1'b0, -1, s);
        hold_trap(11);
        do_reset(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 The block SHALL expose parameter DWIDTH, default 32, retired-instruction counter width.
REQ-002 The block SHALL expose parameter MEM_TIMEOUT, default 16, maximum wait cycles for any memory response.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  leave IDLE and begin fetching.
REQ-006 opcode_i  input  7  opcode of the currently latched instruction, from the decode stage.
REQ-007 br_taken_i  input  1  branch comparison result, valid in EXEC.
REQ-008 imem_req_o  output  1  instruction fetch request.
REQ-009 imem_valid_i  input  1  fetch data valid.
REQ-010 dmem_req_o  output  1  data memory request.
REQ-011 dmem_we_o  output  1  data memory write; 1 for store, 0 for load.
REQ-012 dmem_valid_i  input  1  data access complete.
REQ-013 insn_we_o  output  1  latch fetched instruction into the decode stage.
REQ-014 pc_we_o  output  1  PC register update strobe.
REQ-015 pc_sel_o  output  2  next PC: 00 = pc+4, 01 = pc+imm, 10 = (rs1+imm) & ~1.
REQ-016 rf_we_o  output  1  register-file write strobe.
REQ-017 wb_sel_o  output  2  writeback source: 00 = ALU, 01 = memory, 10 = pc+4.
REQ-018 state_o  output  3  current state encoding.
REQ-019 trap_o  output  1  sticky fault flag.
REQ-020 retire_cnt_o  output  DWIDTH  count of retired instructions.

Function
REQ-021 States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; state_o SHALL be registered.
REQ-022 IDLE: go to FETCH when start_i=1; otherwise stay in IDLE.
REQ-023 FETCH: drive imem_req_o=1 each cycle until imem_valid_i=1; in the valid cycle, pulse insn_we_o=1 and go to DECODE.
REQ-024 DECODE: lasts exactly 1 cycle, classifies opcode_i, and goes to EXEC.
REQ-025 Legal opcodes (binary): R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-026 Any other opcode SHALL go from DECODE to TRAP.
REQ-027 EXEC: lasts 1 cycle; LOAD and STORE go to MEM, all other legal opcodes go to WB.
REQ-028 MEM: drive dmem_req_o=1 until dmem_valid_i=1, with dmem_we_o=1 for STORE and 0 for LOAD; on valid go to WB.
REQ-029 WB: lasts 1 cycle and pulses pc_we_o=1, then goes to FETCH.
REQ-030 WB rf_we_o: 1 for all legal opcodes except STORE and BRANCH.
REQ-031 WB wb_sel_o: 01 for LOAD, 10 for JAL/JALR, otherwise 00.
REQ-032 WB pc_sel_o: 01 for JAL or (BRANCH and br_taken_i latched in EXEC), 10 for JALR, otherwise 00.
REQ-033 Outside the cycles named in REQ-023 and REQ-028..032, all strobes (imem_req_o, dmem_req_o, dmem_we_o, insn_we_o, pc_we_o, rf_we_o) SHALL be 0, and pc_sel_o and wb_sel_o SHALL be 00.
REQ-034 Wait counter: cleared on entry to FETCH or MEM and incremented each cycle a request is waiting.
REQ-035 If the wait counter reaches MEM_TIMEOUT without a valid response, go to TRAP next cycle; a valid arriving in that same cycle wins.
REQ-036 retire_cnt_o SHALL increment by 1 in every WB cycle and wrap from all-ones to 0.
REQ-037 TRAP: absorbing; trap_o=1, all strobes 0, and only rst exits.
REQ-038 Unsolicited imem_valid_i or dmem_valid_i outside FETCH or MEM SHALL be ignored.

Reset
REQ-039 While rst=1 at a clock edge, the next state SHALL be IDLE, all outputs 0, and the wait counter and retire_cnt_o 0.
REQ-040 rst SHALL override every other input in any state, including mid-handshake and TRAP.
REQ-041 After rst, the block SHALL NOT fetch until start_i=1.

Verification
REQ-042 ADD (0110011), imem_valid_i on 1st request cycle -> states 1,2,3,5,1; rf_we_o=1 and wb_sel_o=00 in WB; retire_cnt_o goes 0->1.
REQ-043 LOAD, dmem_valid_i after 3 wait cycles -> dmem_req_o high 4 cycles with dmem_we_o=0; WB has wb_sel_o=01 and rf_we_o=1.
REQ-044 BRANCH with br_taken_i=1, then with 0 -> pc_sel_o=01 then 00 in WB; rf_we_o=0 in both.
REQ-045 Opcode 0000000 -> TRAP with trap_o=1 held for 10+ cycles; then rst=1 for 1 cycle -> IDLE with all outputs 0.
REQ-046 imem_valid_i withheld with MEM_TIMEOUT=16 -> TRAP after 16 request cycles; valid arriving on the 16th cycle -> DECODE instead.
REQ-047 DWIDTH=4, retire 17 instructions -> retire_cnt_o wraps to 1; rst asserted mid-MEM -> IDLE next cycle with dmem_req_o=0.
